// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the multi-cycle data-memory stage.
//   state_t : control FSM states (IDLE, BUSY, DONE, HALTED)
//   op_t    : latched access kind (OP_RD, OP_WR)
//   clog2   : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      DONE   = 2'd2,
      HALTED = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Returns ceil(log2(value)); clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/data_mem_mc_if.sv
// ---------------------------------------------------------------------------
// data_mem_mc_if
// Request/response bundle between the pipeline control and the data memory.
//   master (pipeline side) drives : req_rd, req_wr, addr, wdata, halt
//   slave  (memory side)   drives : rdata, stall, done, err, halted
// ---------------------------------------------------------------------------
interface data_mem_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);

   logic              req_rd;
   logic              req_wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              halt;
   logic [DATA_W-1:0] rdata;
   logic              stall;
   logic              done;
   logic              err;
   logic              halted;

   modport master (
      output req_rd, req_wr, addr, wdata, halt,
      input  rdata, stall, done, err, halted
   );

   modport slave (
      input  req_rd, req_wr, addr, wdata, halt,
      output rdata, stall, done, err, halted
   );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port word RAM, synchronous write and synchronous read.
//   clk   : clock
//   we    : write enable, wdata stored at idx on the rising edge
//   re    : read enable, rdata loads mem[idx] on the rising edge
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
// ---------------------------------------------------------------------------
module dmem_array #(
   parameter int DATA_W  = 16,
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               we,
   input  logic               re,
   input  logic [DEPTH_W-1:0] idx,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_W];

   // NOTE: the storage array has no reset so it maps onto a RAM macro; its
   // contents are undefined after power-up.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesised flops.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_mc.sv
// ---------------------------------------------------------------------------
// data_mem_mc
// Multi-cycle data-memory stage: a word RAM behind a wait-state FSM that
// stalls the pipeline while an access is outstanding, flags misaligned or
// read+write requests, and stops accepting work after a halt drains.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of data_mem_mc_if
//         in  : req_rd, req_wr, addr, wdata, halt
//         out : rdata (valid with done), stall (combinational), done,
//               err (one-cycle pulse), halted (sticky)
// ---------------------------------------------------------------------------
module data_mem_mc
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH_W     = 10,
   parameter int WAIT_CYC    = 2,
   parameter int ALIGN_CHECK = 1
) (
   input logic          clk,
   input logic          rst,
   data_mem_mc_if.slave bus
);

   localparam int BOFF  = clog2(DATA_W / 8);
   localparam int CNT_W = (clog2(WAIT_CYC + 1) < 1) ? 1 : clog2(WAIT_CYC + 1);
   // BUSY lasts WAIT_CYC cycles (the request cycle is the first of the
   // WAIT_CYC+1 latency), so the counter starts one below WAIT_CYC and the
   // access fires in the BUSY cycle where it reads zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   op_t                op_q;
   logic [DEPTH_W-1:0] idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               err_q, err_d;
   logic               halt_q;
   logic               rdata_ok;

   logic               misaligned;
   logic               valid_req;
   logic               bad_req;
   logic               take;
   logic               access;
   op_t                live_op;
   op_t                mem_op;
   logic [DEPTH_W-1:0] live_idx;
   logic [DEPTH_W-1:0] mem_idx;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_we;
   logic               mem_re;
   logic               unused_addr_bits;

   // Upper address bits are deliberately ignored: addresses wrap modulo depth.
   assign unused_addr_bits = ^bus.addr;

   assign live_idx   = bus.addr[BOFF+DEPTH_W-1:BOFF];
   assign live_op    = bus.req_wr ? OP_WR : OP_RD;
   assign misaligned = (ALIGN_CHECK != 0) && (bus.addr[BOFF-1:0] != '0);
   assign valid_req  = (bus.req_rd ^ bus.req_wr) && !misaligned;
   assign bad_req    = (bus.req_rd && bus.req_wr) ||
                       ((bus.req_rd || bus.req_wr) && misaligned);

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      err_d   = 1'b0;
      take    = 1'b0;
      access  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (bus.halt || halt_q) begin
               // A halt (live or latched during the last access) wins over
               // any request presented in the same cycle.
               state_d = HALTED;
            end else if (valid_req) begin
               take  = 1'b1;
               cnt_d = CNT_LOAD;
               if (WAIT_CYC == 0) begin
                  access  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end else begin
               err_d   = bad_req;
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               cnt_d = cnt - CNT_W'(1);
            end else begin
               access  = 1'b1;
               state_d = DONE;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // In BUSY the latched request drives the RAM; a zero-wait access is
   // issued straight from the live inputs in the request cycle.
   assign mem_op    = (state == BUSY) ? op_q    : live_op;
   assign mem_idx   = (state == BUSY) ? idx_q   : live_idx;
   assign mem_wdata = (state == BUSY) ? wdata_q : bus.wdata;
   assign mem_we    = access && (mem_op == OP_WR);
   assign mem_re    = access && (mem_op == OP_RD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= OP_RD;
         idx_q    <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         halt_q   <= 1'b0;
         rdata_ok <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         err_q <= err_d;
         if (take) begin
            op_q    <= live_op;
            idx_q   <= live_idx;
            wdata_q <= bus.wdata;
         end
         if ((state == BUSY) && bus.halt) begin
            halt_q <= 1'b1;
         end
         if (mem_re) begin
            rdata_ok <= 1'b1;
         end
      end
   end

   dmem_array #(
      .DATA_W  (DATA_W),
      .DEPTH_W (DEPTH_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .idx   (mem_idx),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // The RAM read register is not reset, so rdata is masked to zero until
   // the first read after reset has loaded it.
   assign bus.rdata  = rdata_ok ? mem_rdata : '0;
   assign bus.stall  = (state == BUSY) || take;
   assign bus.done   = (state == DONE);
   assign bus.err    = err_q;
   assign bus.halted = (state == HALTED);

endmodule

// File: tb/tb_data_mem_mc.sv
// ---------------------------------------------------------------------------
// tb_data_mem_mc
// Two instances share clock and reset:
//   dut_a : DEPTH_W=10, WAIT_CYC=2
//   dut_b : DEPTH_W=4,  WAIT_CYC=0
// The driver pushes the expected response (due cycle, kind, data) into a
// per-instance queue; a negedge monitor pops and compares whenever the due
// cycle arrives or the DUT raises done/err.
// ---------------------------------------------------------------------------
module tb_data_mem_mc;

   typedef struct {
      int          due;
      bit          is_err;
      bit          chk;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [15:0] mem0 [int];
   logic [15:0] mem1 [int];
   bit          halted_m [2];

   data_mem_mc_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
   data_mem_mc_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();

   data_mem_mc #(
      .DATA_W(16), .ADDR_W(16), .DEPTH_W(10), .WAIT_CYC(2), .ALIGN_CHECK(1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   data_mem_mc #(
      .DATA_W(16), .ADDR_W(16), .DEPTH_W(4), .WAIT_CYC(0), .ALIGN_CHECK(1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic get_stall(input int ch);
      return (ch == 0) ? bus_a.stall : bus_b.stall;
   endfunction

   task automatic drive(input int ch, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d, input logic h);
      if (ch == 0) begin
         bus_a.req_rd = rd; bus_a.req_wr = wr; bus_a.addr = a; bus_a.wdata = d; bus_a.halt = h;
      end else begin
         bus_b.req_rd = rd; bus_b.req_wr = wr; bus_b.addr = a; bus_b.wdata = d; bus_b.halt = h;
      end
   endtask

   // Reference mapping: byte address -> word, modulo the instance depth.
   function automatic int word_of(input int ch, input logic [15:0] a);
      int depth;
      depth = (ch == 0) ? 1024 : 16;
      return (int'(a) / 2) % depth;
   endfunction

   task automatic push_exp(input int ch, input exp_t e);
      if (ch == 0) sb0.push_back(e);
      else         sb1.push_back(e);
   endtask

   function automatic int sb_size(input int ch);
      return (ch == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic int sb_due(input int ch);
      return (ch == 0) ? sb0[0].due : sb1[0].due;
   endfunction

   function automatic exp_t sb_pop(input int ch);
      if (ch == 0) return sb0.pop_front();
      return sb1.pop_front();
   endfunction

   // Issue one request at the current negedge and hold it while the DUT is
   // expected to stall. Returns at the negedge of the completion (or err)
   // cycle with the request still driven; the caller replaces it at once.
   task automatic op(input int ch, input bit rd, input bit wr,
                     input logic [15:0] a, input logic [15:0] d);
      int   wc;
      int   idx;
      int   t0;
      bit   mis;
      bit   valid;
      bit   bad;
      exp_t e;
      wc    = (ch == 0) ? 2 : 0;
      mis   = (a % 2) != 0;
      valid = (rd != wr) && !mis && !halted_m[ch];
      bad   = ((rd && wr) || ((rd || wr) && mis)) && !halted_m[ch];
      idx   = word_of(ch, a);
      t0    = cyc;
      drive(ch, rd, wr, a, d, 1'b0);
      e.is_err = 1'b0; e.chk = 1'b0; e.data = '0; e.due = t0 + wc + 1;
      if (valid) begin
         if (wr) begin
            if (ch == 0) mem0[idx] = d;
            else         mem1[idx] = d;
         end else if (ch == 0 && mem0.exists(idx)) begin
            e.chk = 1'b1; e.data = mem0[idx];
         end else if (ch == 1 && mem1.exists(idx)) begin
            e.chk = 1'b1; e.data = mem1[idx];
         end
         push_exp(ch, e);
      end else if (bad) begin
         e.due = t0 + 1; e.is_err = 1'b1;
         push_exp(ch, e);
      end
      #1 check($sformatf("stall_req_ch%0d", ch), get_stall(ch), valid);
      if (valid) begin
         for (int k = 1; k <= wc; k++) begin
            @(negedge clk);
            check($sformatf("stall_busy_ch%0d", ch), get_stall(ch), 1'b1);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int ch, input int n);
      drive(ch, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #1 check($sformatf("stall_idle_ch%0d", ch), get_stall(ch), 1'b0);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b0;
      sb0.delete();
      sb1.delete();
      halted_m[0] = 1'b0;
      halted_m[1] = 1'b0;
      #1;
      check("rst_rdata_a",  bus_a.rdata,  16'h0000);
      check("rst_stall_a",  bus_a.stall,  1'b0);
      check("rst_done_a",   bus_a.done,   1'b0);
      check("rst_err_a",    bus_a.err,    1'b0);
      check("rst_halted_a", bus_a.halted, 1'b0);
      check("rst_rdata_b",  bus_b.rdata,  16'h0000);
      check("rst_stall_b",  bus_b.stall,  1'b0);
      check("rst_done_b",   bus_b.done,   1'b0);
      check("rst_err_b",    bus_b.err,    1'b0);
      check("rst_halted_b", bus_b.halted, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic mon(input int ch, input logic done, input logic err, input logic [15:0] rdata);
      exp_t  e;
      string tag;
      tag = (ch == 0) ? "a" : "b";
      if (sb_size(ch) > 0 && sb_due(ch) == cyc) begin
         e = sb_pop(ch);
         check($sformatf("done_%s", tag), done, !e.is_err);
         check($sformatf("err_%s", tag), err, e.is_err);
         if (e.chk) check($sformatf("rdata_%s", tag), rdata, e.data);
      end else if (done || err) begin
         check($sformatf("spurious_done_err_%s", tag), {done, err}, 2'b00);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mon(0, bus_a.done, bus_a.err, bus_a.rdata);
         mon(1, bus_b.done, bus_b.err, bus_b.rdata);
      end
   end

   task automatic random_phase(input int ch);
      int          kind;
      int          w;
      logic [15:0] a;
      logic [15:0] d;
      bit          r;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         w    = $urandom_range(0, 11);
         a    = 16'(w * 2) + 16'(((ch == 0) ? 2048 : 32) * $urandom_range(0, 3));
         d    = 16'($urandom);
         r    = 1'($urandom_range(0, 1));
         case (kind)
            0:       op(ch, 1'b1, 1'b1, a, d);
            1:       op(ch, r, !r, a | 16'h0001, d);
            2, 3, 4, 5: op(ch, 1'b0, 1'b1, a, d);
            default: op(ch, 1'b1, 1'b0, a, d);
         endcase
         if ($urandom_range(0, 3) == 0) idle(ch, $urandom_range(1, 2));
      end
      idle(ch, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      exp_t e;
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      do_reset();

      // dut_a: write then read back, stall cycles 0..2, done in cycle 3
      op(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
      idle(0, 1);
      op(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(0, 1);
      // misaligned read: err in cycle 1, no stall, memory intact
      op(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
      idle(0, 1);
      check("misaligned_no_stall", bus_a.stall, 1'b0);
      op(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(0, 1);
      // read+write conflict: err pulse, no access
      op(0, 1'b0, 1'b1, 16'h0020, 16'h0C0C);
      idle(0, 1);
      op(0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
      idle(0, 1);
      op(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      idle(0, 1);

      // reset asserted in cycle 1 of a write: write never commits
      op(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
      idle(0, 1);
      drive(0, 1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
      #1 check("rstmid_stall", bus_a.stall, 1'b1);
      @(negedge clk);
      do_reset();
      op(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      idle(0, 1);

      // dut_b: wrap-around and back-to-back zero-wait accesses
      op(1, 1'b0, 1'b1, 16'h0002, 16'h1234);
      idle(1, 1);
      op(1, 1'b1, 1'b0, 16'h0022, 16'h0000);
      op(1, 1'b0, 1'b1, 16'h0004, 16'h4444);
      op(1, 1'b0, 1'b1, 16'h0006, 16'h6666);
      op(1, 1'b1, 1'b0, 16'h0024, 16'h0000);
      op(1, 1'b1, 1'b0, 16'h0006, 16'h0000);
      op(1, 1'b1, 1'b0, 16'h0042, 16'h0000);
      idle(1, 2);

      random_phase(0);
      random_phase(1);

      // halt in cycle 1 of a read: read completes, then halted
      drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      t0 = cyc;
      e.due = t0 + 3; e.is_err = 1'b0; e.chk = 1'b1; e.data = mem0[word_of(0, 16'h0010)];
      sb0.push_back(e);
      #1 check("halt_stall_c0", bus_a.stall, 1'b1);
      @(negedge clk);
      bus_a.halt = 1'b1;
      #1 check("halt_stall_c1", bus_a.stall, 1'b1);
      @(negedge clk);
      bus_a.halt = 1'b0;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #1 check("halt_not_yet", bus_a.halted, 1'b0);
      @(negedge clk);
      check("halted_set", bus_a.halted, 1'b1);
      halted_m[0] = 1'b1;
      op(0, 1'b0, 1'b1, 16'h0010, 16'h1111);
      op(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(0, 3);
      check("halted_sticky", bus_a.halted, 1'b1);
      do_reset();
      op(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(0, 2);

      check("sb_a_drained", sb0.size(), 0);
      check("sb_b_drained", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
